// File: rtl/pulse_cmd_sequencer.sv
// Command-frame front end for the two-channel pulse generator: frames UART bytes, clamps and
// applies config when the generator is idle, and merges key/UART triggers. Optional macro: PULSE_CMD_CHECKSUM_EN.
`timescale 1ns/1ps
module pulse_cmd_sequencer #(
  parameter logic [7:0]  HEADER      = 8'h07,
  parameter logic [15:0] MIN_WIDTH   = 16'd4,
  parameter logic [15:0] RST_WIDTH   = 16'd5,
  parameter int          TIMEOUT_CYC = 500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        key_trig,
  input  logic        gen_busy,
  output logic [1:0]  pulse_select,
  output logic [15:0] pulse_width1,
  output logic [15:0] pulse_width2,
  output logic [15:0] pulse_gap,
  output logic        gen_start,
  output logic [7:0]  ack_data,
  output logic        ack_valid
);

`ifdef PULSE_CMD_CHECKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif
  // Bytes shift in from the bottom, so byte Bk of the frame lands at index FRAME_LEN-k.
  localparam int OFS   = FRAME_LEN - 9;
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

  state_t                     state_r, state_s;
  logic [3:0]                 cnt_r;
  logic [TMO_W-1:0]           tmo_cnt_r;
  logic [FRAME_LEN-1:1][7:0]  frame_r;
  logic [1:0]                 sh_sel_r;
  logic [15:0]                sh_w1_r, sh_w2_r, sh_gap_r;
  logic                       apply_pend_r, trig_pend_r;
  logic                       ack_set_s, load_shadow_s, csum_ok_s;
  logic                       apply_fire_s, start_fire_s, hdr_seen_s;
  logic [7:0]                 ack_code_s;

  function automatic logic [15:0] clamp_min(input logic [15:0] v);
    if (v < MIN_WIDTH) clamp_min = MIN_WIDTH;
    else               clamp_min = v;
  endfunction

`ifdef PULSE_CMD_CHECKSUM_EN
  // XOR over header, payload and check byte; a good frame folds to zero.
  function automatic logic [7:0] frame_xor(input logic [FRAME_LEN-1:1][7:0] f);
    logic [7:0] acc;
    acc = HEADER;
    for (int i = 1; i < FRAME_LEN; i++) acc = acc ^ f[i];
    frame_xor = acc;
  endfunction
  assign csum_ok_s = (frame_xor(frame_r) == 8'h00);
`else
  assign csum_ok_s = 1'b1;
`endif

  assign hdr_seen_s   = rx_valid && (rx_byte == HEADER);
  assign apply_fire_s = apply_pend_r && !gen_busy;
  assign start_fire_s = trig_pend_r && !gen_busy && !apply_pend_r;

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_r <= HUNT;
    else            state_r <= state_s;
  end

  // Next-state and ack/shadow-load decode.
  always_comb begin
    state_s       = state_r;
    ack_set_s     = 1'b0;
    ack_code_s    = 8'h00;
    load_shadow_s = 1'b0;
    case (state_r)
      HUNT: begin
        if (hdr_seen_s) state_s = COLLECT;
        else            state_s = HUNT;
      end
      COLLECT: begin
        if (rx_valid) begin
          if (cnt_r == 4'(FRAME_LEN - 1)) state_s = CHECK;
          else                            state_s = COLLECT;
        end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_s    = HUNT;
          ack_set_s  = 1'b1;
          ack_code_s = 8'hE2;
        end else begin
          state_s = COLLECT;
        end
      end
      CHECK: begin
        ack_set_s = 1'b1;
        if (csum_ok_s) begin
          load_shadow_s = 1'b1;
          ack_code_s    = 8'hA5;
        end else begin
          ack_code_s    = 8'hE1;
        end
        // A byte landing in this cycle is hunted like any other.
        if (hdr_seen_s) state_s = COLLECT;
        else            state_s = HUNT;
      end
      default: state_s = HUNT;
    endcase
  end

  // Frame byte capture, byte counter and silence timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_r     <= 4'd0;
      tmo_cnt_r <= '0;
      frame_r   <= '0;
    end else begin
      if (state_r == COLLECT && rx_valid) begin
        frame_r <= {frame_r[FRAME_LEN-2:1], rx_byte};
        cnt_r   <= cnt_r + 4'd1;
      end else if (state_r != COLLECT && hdr_seen_s) begin
        cnt_r   <= 4'd1;
      end else if (state_r != COLLECT) begin
        cnt_r   <= 4'd0;
      end
      if (state_r != COLLECT || rx_valid) tmo_cnt_r <= '0;
      else                                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Shadow config: clamped fields of the last good frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_sel_r <= 2'b00;
      sh_w1_r  <= RST_WIDTH;
      sh_w2_r  <= RST_WIDTH;
      sh_gap_r <= RST_WIDTH;
    end else if (load_shadow_s) begin
      sh_sel_r <= {frame_r[7+OFS] == 8'h01, frame_r[8+OFS] == 8'h01};
      sh_w1_r  <= clamp_min({frame_r[6+OFS], frame_r[5+OFS]});
      sh_w2_r  <= clamp_min({frame_r[4+OFS], frame_r[3+OFS]});
      sh_gap_r <= clamp_min({frame_r[2+OFS], frame_r[1+OFS]});
    end
  end

  // Apply/trigger scheduler: config only moves while the generator is idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      apply_pend_r <= 1'b0;
      trig_pend_r  <= 1'b0;
      gen_start    <= 1'b0;
      pulse_select <= 2'b00;
      pulse_width1 <= RST_WIDTH;
      pulse_width2 <= RST_WIDTH;
      pulse_gap    <= RST_WIDTH;
    end else begin
      if (load_shadow_s)     apply_pend_r <= 1'b1;
      else if (apply_fire_s) apply_pend_r <= 1'b0;
      if (apply_fire_s || key_trig) trig_pend_r <= 1'b1;
      else if (start_fire_s)        trig_pend_r <= 1'b0;
      gen_start <= start_fire_s;
      if (apply_fire_s) begin
        pulse_select <= sh_sel_r;
        pulse_width1 <= sh_w1_r;
        pulse_width2 <= sh_w2_r;
        pulse_gap    <= sh_gap_r;
      end
    end
  end

  // Registered status strobe; ack_data holds the last code.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_valid <= 1'b0;
      ack_data  <= 8'h00;
    end else begin
      ack_valid <= ack_set_s;
      if (ack_set_s) ack_data <= ack_code_s;
    end
  end

endmodule

// File: tb/tb_pulse_cmd_sequencer.sv
// Directed self-checking bench for pulse_cmd_sequencer (silence timeout shortened to 200 cycles).
`timescale 1ns/1ps
module tb_pulse_cmd_sequencer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        key_trig = 1'b0;
  logic        gen_busy = 1'b0;
  logic [1:0]  pulse_select;
  logic [15:0] pulse_width1, pulse_width2, pulse_gap;
  logic        gen_start;
  logic [7:0]  ack_data;
  logic        ack_valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int start_cnt = 0;
  int ack_cnt = 0;
  logic [7:0] last_ack = 8'h00;

  logic [7:0] fa [9] = '{8'h07, 8'h01, 8'h01, 8'h00, 8'h64, 8'h00, 8'hC8, 8'h01, 8'hF4};
  logic [7:0] fb [9] = '{8'h07, 8'h01, 8'h00, 8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] fc [9] = '{8'h07, 8'h00, 8'h01, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40};
  logic [7:0] fd [9] = '{8'h07, 8'h01, 8'h01, 8'h00, 8'h08, 8'h00, 8'h09, 8'h00, 8'h0A};
  logic [7:0] fe [9] = '{8'h07, 8'h02, 8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};

  pulse_cmd_sequencer #(.TIMEOUT_CYC(200)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .key_trig(key_trig), .gen_busy(gen_busy), .pulse_select(pulse_select),
    .pulse_width1(pulse_width1), .pulse_width2(pulse_width2), .pulse_gap(pulse_gap),
    .gen_start(gen_start), .ack_data(ack_data), .ack_valid(ack_valid)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (gen_start === 1'b1) start_cnt <= start_cnt + 1;
    if (ack_valid === 1'b1) begin
      ack_cnt  <= ack_cnt + 1;
      last_ack <= ack_data;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [9], input logic bad);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 9; i++) begin
      send_byte(f[i]);
      cs = cs ^ f[i];
    end
`ifdef PULSE_CMD_CHECKSUM_EN
    if (bad) cs = cs ^ 8'hFF;
    send_byte(cs);
`endif
  endtask

  task automatic chk_cfg(input string tag, input logic [1:0] s, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] g);
    chk({tag, "_sel"}, 32'(pulse_select), 32'(s));
    chk({tag, "_w1"},  32'(pulse_width1), 32'(w1));
    chk({tag, "_w2"},  32'(pulse_width2), 32'(w2));
    chk({tag, "_gap"}, 32'(pulse_gap),    32'(g));
  endtask

  initial begin
    int st0, ak0;
    tick(3);
    sys_rst_n = 1'b1;
    tick(1);
    chk_cfg("rst", 2'b00, 16'd5, 16'd5, 16'd5);
    chk("rst_start", 32'(gen_start), 32'd0);
    chk("rst_ackv", 32'(ack_valid), 32'd0);
    chk("rst_ackd", 32'(ack_data), 32'd0);

    // Key trigger on idle generator: one start one cycle after the press.
    st0 = start_cnt;
    key_trig = 1'b1;
    tick(1);
    key_trig = 1'b0;
    chk("key_start0", 32'(gen_start), 32'd0);
    tick(1);
    chk("key_start1", 32'(gen_start), 32'd1);
    tick(1);
    chk("key_count", 32'(start_cnt - st0), 32'd1);
    chk_cfg("key_cfg", 2'b00, 16'd5, 16'd5, 16'd5);

    // Frame A, idle generator: ack N+1, outputs N+2, start N+3.
    st0 = start_cnt;
    send_frame(fa, 1'b0);
    chk("a_ack_early", 32'(ack_valid), 32'd0);
    tick(1);
    chk("a_ackv", 32'(ack_valid), 32'd1);
    chk("a_ackd", 32'(ack_data), 32'hA5);
    chk_cfg("a_cfg_hold", 2'b00, 16'd5, 16'd5, 16'd5);
    tick(1);
    chk_cfg("a_cfg", 2'b11, 16'd100, 16'd200, 16'd500);
    chk("a_start_n2", 32'(gen_start), 32'd0);
    tick(1);
    chk("a_start_n3", 32'(gen_start), 32'd1);
    tick(1);
    chk("a_start_cnt", 32'(start_cnt - st0), 32'd1);

    // Frame B while busy: clamped, held until busy drops.
    st0 = start_cnt;
    gen_busy = 1'b1;
    send_frame(fb, 1'b0);
    tick(1);
    chk("b_ackd", 32'(ack_data), 32'hA5);
    tick(5);
    chk_cfg("b_hold", 2'b11, 16'd100, 16'd200, 16'd500);
    chk("b_nostart", 32'(start_cnt - st0), 32'd0);
    gen_busy = 1'b0;
    tick(1);
    chk_cfg("b_cfg", 2'b01, 16'd4, 16'd256, 16'd4);
    chk("b_start0", 32'(gen_start), 32'd0);
    tick(1);
    chk("b_start1", 32'(gen_start), 32'd1);
    tick(1);

    // Stray non-header byte in HUNT: silently dropped.
    ak0 = ack_cnt;
    send_byte(8'h55);
    tick(5);
    chk("stray_noack", 32'(ack_cnt - ak0), 32'd0);

    // Partial frame then silence: E2, then a full frame recovers.
    ak0 = ack_cnt;
    st0 = start_cnt;
    send_byte(8'h07); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    tick(300);
    chk("tmo_ackcnt", 32'(ack_cnt - ak0), 32'd1);
    chk("tmo_code", 32'(last_ack), 32'hE2);
    chk_cfg("tmo_hold", 2'b01, 16'd4, 16'd256, 16'd4);
    send_frame(fc, 1'b0);
    tick(4);
    chk("c_ackcnt", 32'(ack_cnt - ak0), 32'd2);
    chk("c_code", 32'(last_ack), 32'hA5);
    chk_cfg("c_cfg", 2'b10, 16'd32, 16'd48, 16'd64);
    chk("c_start_cnt", 32'(start_cnt - st0), 32'd1);

    // Key press landing on the apply cycle merges into one start.
    st0 = start_cnt;
    send_frame(fa, 1'b0);
    tick(1);
    key_trig = 1'b1;
    tick(1);
    key_trig = 1'b0;
    tick(5);
    chk("merge_cnt", 32'(start_cnt - st0), 32'd1);
    chk_cfg("merge_cfg", 2'b11, 16'd100, 16'd200, 16'd500);

    // Three key presses and a frame during busy: one start after busy drops.
    st0 = start_cnt;
    gen_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_trig = 1'b1;
      tick(1);
      key_trig = 1'b0;
      tick(2);
    end
    send_frame(fd, 1'b0);
    tick(5);
    chk("busy_nostart", 32'(start_cnt - st0), 32'd0);
    chk_cfg("busy_hold", 2'b11, 16'd100, 16'd200, 16'd500);
    gen_busy = 1'b0;
    tick(6);
    chk("busy_one_start", 32'(start_cnt - st0), 32'd1);
    chk_cfg("d_cfg", 2'b11, 16'd8, 16'd9, 16'd10);

`ifdef PULSE_CMD_CHECKSUM_EN
    // Bad check byte: E1, nothing applied; good one: A5 and a start.
    st0 = start_cnt;
    send_frame(fe, 1'b1);
    tick(5);
    chk("cs_bad_code", 32'(last_ack), 32'hE1);
    chk_cfg("cs_bad_hold", 2'b11, 16'd8, 16'd9, 16'd10);
    chk("cs_bad_nostart", 32'(start_cnt - st0), 32'd0);
    send_frame(fe, 1'b0);
    tick(5);
    chk("cs_good_code", 32'(last_ack), 32'hA5);
    chk_cfg("cs_good_cfg", 2'b10, 16'd256, 16'd512, 16'd768);
    chk("cs_good_start", 32'(start_cnt - st0), 32'd1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
